// File: rtl/imm_encoder.sv
// imm_encoder: packs RV32I fields plus a signed immediate into an instruction
// word (R/I/S/B/U/J). The request first lands in stage 1, where it is checked
// for immediate range and alignment. Stage 2 then holds the packed word, or a
// NOP with the error flag set. Saturating counters track legal and illegal
// requests.
// Optional build macro: IMM_ROUNDTRIP_CHECK_EN adds the rt_mismatch output.
module imm_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
`ifdef IMM_ROUNDTRIP_CHECK_EN
  output logic             rt_mismatch,
`endif
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic             s1_valid_q;
  logic [2:0]       s1_fmt_q;
  logic [6:0]       s1_op_q;
  logic [4:0]       s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [2:0]       s1_f3_q;
  logic [6:0]       s1_f7_q;
  logic [31:0]      s1_imm_q;

  logic             out_valid_q, out_err_q;
  logic [31:0]      out_inst_q;
  logic [CNT_W-1:0] enc_cnt_q, err_cnt_q;

  logic             s2_adv;
  logic             legal_d;
  logic [31:0]      inst_d;

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;
  assign enc_cnt   = enc_cnt_q;
  assign err_cnt   = err_cnt_q;

  // Legality check and word packing from the stage-1 registers
  always_comb begin
    legal_d = 1'b0;
    inst_d  = NOP;
    case (s1_fmt_q)
      FMT_R: begin
        legal_d = 1'b1;
        inst_d  = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      end
      FMT_I: begin
        legal_d = (s1_imm_q[31:11] == '0) || (s1_imm_q[31:11] == '1);
        inst_d  = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      end
      FMT_S: begin
        legal_d = (s1_imm_q[31:11] == '0) || (s1_imm_q[31:11] == '1);
        inst_d  = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], s1_op_q};
      end
      FMT_B: begin
        legal_d = !s1_imm_q[0] &&
                  ((s1_imm_q[31:12] == '0) || (s1_imm_q[31:12] == '1));
        inst_d  = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                   s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
      end
      FMT_U: begin
        legal_d = (s1_imm_q[11:0] == '0);
        inst_d  = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
      end
      FMT_J: begin
        legal_d = !s1_imm_q[0] &&
                  ((s1_imm_q[31:20] == '0) || (s1_imm_q[31:20] == '1));
        inst_d  = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                   s1_rd_q, s1_op_q};
      end
      default: begin
        legal_d = 1'b0;
        inst_d  = NOP;
      end
    endcase
    if (!legal_d) inst_d = NOP;
  end

`ifdef IMM_ROUNDTRIP_CHECK_EN
  logic [31:0] rt_imm_d;
  logic        rt_mis_d;
  logic        rt_mis_q;

  // Re-extract the immediate from the packed word and compare to the request
  always_comb begin
    rt_imm_d = '0;
    case (s1_fmt_q)
      FMT_I:   rt_imm_d = {{20{inst_d[31]}}, inst_d[31:20]};
      FMT_S:   rt_imm_d = {{20{inst_d[31]}}, inst_d[31:25], inst_d[11:7]};
      FMT_B:   rt_imm_d = {{19{inst_d[31]}}, inst_d[31], inst_d[7], inst_d[30:25],
                           inst_d[11:8], 1'b0};
      FMT_U:   rt_imm_d = {inst_d[31:12], 12'b0};
      FMT_J:   rt_imm_d = {{11{inst_d[31]}}, inst_d[31], inst_d[19:12], inst_d[20],
                           inst_d[30:21], 1'b0};
      default: rt_imm_d = '0;
    endcase
    rt_mis_d = legal_d && (s1_fmt_q != FMT_R) && (rt_imm_d != s1_imm_q);
  end

  // Round-trip flag travels with the stage-2 word
  always_ff @(posedge clk) begin
    if (rst)                      rt_mis_q <= 1'b0;
    else if (s2_adv && s1_valid_q) rt_mis_q <= rt_mis_d;
  end

  assign rt_mismatch = rt_mis_q;
`endif

  // Stage 1: capture accepted requests
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_fmt_q   <= '0;
      s1_op_q    <= '0;
      s1_rd_q    <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_f3_q    <= '0;
      s1_f7_q    <= '0;
      s1_imm_q   <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_fmt_q <= in_fmt;
        s1_op_q  <= in_opcode;
        s1_rd_q  <= in_rd;
        s1_rs1_q <= in_rs1;
        s1_rs2_q <= in_rs2;
        s1_f3_q  <= in_funct3;
        s1_f7_q  <= in_funct7;
        s1_imm_q <= in_imm;
      end
    end
  end

  // Stage 2: output register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_err_q   <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_inst_q <= inst_d;
        out_err_q  <= !legal_d;
      end
    end
  end

  // Saturating counters, bumped once per stage-1 to stage-2 transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (s2_adv && s1_valid_q) begin
      if (legal_d) begin
        if (!(&enc_cnt_q)) enc_cnt_q <= enc_cnt_q + CNT_W'(1);
      end else begin
        if (!(&err_cnt_q)) err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vectors, illegal cases, back-pressure,
// random streaming against an arithmetic reference model, reset and
// counter saturation (small counter width).
module tb_imm_encoder;
  localparam int unsigned CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_fmt = '0;
  logic [6:0]    in_opcode = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_inst;
  logic          out_err;
  logic [CW-1:0] enc_cnt, err_cnt;
`ifdef IMM_ROUNDTRIP_CHECK_EN
  logic          rt_mismatch;
`endif

  always #5 clk = ~clk;

  imm_encoder #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err),
`ifdef IMM_ROUNDTRIP_CHECK_EN
    .rt_mismatch(rt_mismatch),
`endif
    .enc_cnt(enc_cnt), .err_cnt(err_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   enc_m = 0, err_m = 0, n_out = 0;
  bit   rand_rdy = 1'b0;

  function automatic logic [31:0] fld(input logic [31:0] x, input int lo, input int n);
    return (x >> lo) & ((32'd1 << n) - 32'd1);
  endfunction

  // Reference: legality from integer ranges, word built by shift-and-add
  function automatic exp_t model(input int fmt, input logic [31:0] op, rd, rs1, rs2,
                                 f3, f7, input logic [31:0] imm);
    exp_t   e;
    longint v = longint'($signed(imm));
    bit     even = (imm % 32'd2) == 0;
    bit     ok;
    logic [31:0] base = op + (f3 << 12);
    case (fmt)
      0: ok = 1;
      1, 2: ok = (v >= -2048) && (v <= 2047);
      3: ok = even && (v >= -4096) && (v <= 4094);
      4: ok = (imm % 32'd4096) == 0;
      5: ok = even && (v >= -1048576) && (v <= 1048574);
      default: ok = 0;
    endcase
    case (fmt)
      0: e.inst = (f7 << 25) + (rs2 << 20) + (rs1 << 15) + base + (rd << 7);
      1: e.inst = (fld(imm, 0, 12) << 20) + (rs1 << 15) + base + (rd << 7);
      2: e.inst = (fld(imm, 5, 7) << 25) + (rs2 << 20) + (rs1 << 15) + base
                  + (fld(imm, 0, 5) << 7);
      3: e.inst = (fld(imm, 12, 1) << 31) + (fld(imm, 5, 6) << 25) + (rs2 << 20)
                  + (rs1 << 15) + base + (fld(imm, 1, 4) << 8) + (fld(imm, 11, 1) << 7);
      4: e.inst = (fld(imm, 12, 20) << 12) + (rd << 7) + op;
      5: e.inst = (fld(imm, 20, 1) << 31) + (fld(imm, 1, 10) << 21) + (fld(imm, 11, 1) << 20)
                  + (fld(imm, 12, 8) << 12) + (rd << 7) + op;
      default: e.inst = 32'h13;
    endcase
    if (!ok) e.inst = 32'h0000_0013;
    e.err = !ok;
    return e;
  endfunction

  // Offer one request; push its expectation at acceptance
  task automatic send(input int fmt, input int op, rd, rs1, rs2, f3, f7,
                      input logic [31:0] imm, input bit direct,
                      input logic [31:0] w_inst, input logic w_err);
    exp_t e;
    bit   done = 0;
    in_fmt = 3'(fmt); in_opcode = 7'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1);
    in_rs2 = 5'(rs2); in_funct3 = 3'(f3); in_funct7 = 7'(f7); in_imm = imm;
    in_valid = 1'b1;
    if (direct) begin
      e.inst = w_inst; e.err = w_err;
    end else begin
      e = model(fmt, op, rd, rs1, rs2, f3, f7, imm);
    end
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        if (e.err) err_m = (err_m < CMAX) ? err_m + 1 : err_m;
        else       enc_m = (enc_m < CMAX) ? enc_m + 1 : enc_m;
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 0, 1);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int k = 0; k < 50 && (exp_q.size() != 0 || out_valid); k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check({tag, "_empty"}, exp_q.size(), 0);
    check({tag, "_enc"}, enc_cnt, enc_m);
    check({tag, "_err"}, err_cnt, err_m);
  endtask

  // Output monitor: scoreboard pops and stall stability
  exp_t        mon_e;
  bit          holding = 0;
  logic [31:0] held;
  always @(negedge clk) begin
    if (holding && out_valid) check("hold_stable", out_inst, held);
    holding = out_valid && !out_ready && !rst;
    held    = out_inst;
    if (out_valid && out_ready && !rst) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_inst", out_inst, mon_e.inst);
        check("out_err", out_err, mon_e.err);
`ifdef IMM_ROUNDTRIP_CHECK_EN
        check("rt_mismatch", rt_mismatch, 0);
`endif
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  int base_out;
  int fmt_r;
  logic [31:0] imm_r;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_inst", out_inst, 0);
    check("rst_out_err", out_err, 0);
    check("rst_enc", enc_cnt, 0);
    check("rst_err", err_cnt, 0);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);

    // First request and its latency
    send(1, 'h13, 1, 0, 0, 0, 0, 32'd5, 1, 32'h0050_0093, 0);
    check("lat_n1", out_valid, 0);
    @(posedge clk); #1;
    check("lat_n2", out_valid, 1);
    check("enc_first", enc_cnt, 1);

    send(3, 'h63, 0, 1, 2, 0, 0, -32'sd8, 1, 32'hFE20_8CE3, 0);
    send(4, 'h37, 5, 0, 0, 0, 0, 32'h1234_5000, 1, 32'h1234_52B7, 0);
    send(5, 'h6F, 1, 0, 0, 0, 0, 32'd2048, 1, 32'h0010_00EF, 0);
    drain("legal");

    // Illegal requests
    send(1, 'h13, 1, 0, 0, 0, 0, 32'd2048, 1, 32'h13, 1);
    send(3, 'h63, 0, 1, 2, 0, 0, 32'd4096, 1, 32'h13, 1);
    send(3, 'h63, 0, 1, 2, 0, 0, 32'd5, 1, 32'h13, 1);
    send(4, 'h37, 5, 0, 0, 0, 0, 32'h1234_5001, 1, 32'h13, 1);
    send(7, 'h33, 1, 2, 3, 0, 0, 32'd0, 1, 32'h13, 1);
    drain("illegal");
    check("err_cnt5", err_cnt, 5);

    // Range boundaries through the model
    send(1, 'h13, 3, 4, 0, 0, 0, 32'd2047, 0, 0, 0);
    send(2, 'h23, 0, 4, 5, 2, 0, -32'sd2048, 0, 0, 0);
    send(3, 'h63, 0, 6, 7, 1, 0, 32'd4094, 0, 0, 0);
    send(3, 'h63, 0, 6, 7, 1, 0, -32'sd4096, 0, 0, 0);
    send(5, 'h6F, 9, 0, 0, 0, 0, 32'd1048574, 0, 0, 0);
    send(5, 'h6F, 9, 0, 0, 0, 0, -32'sd1048576, 0, 0, 0);
    send(0, 'h33, 7, 8, 9, 5, 'h20, 32'hDEAD_BEEF, 0, 0, 0);
    drain("bound");

    // Back-pressure: two fit, the third waits
    base_out = n_out;
    out_ready = 1'b0;
    send(1, 'h13, 10, 11, 0, 0, 0, 32'd100, 0, 0, 0);
    send(1, 'h13, 12, 13, 0, 0, 0, 32'd200, 0, 0, 0);
    fork
      send(1, 'h13, 14, 15, 0, 0, 0, 32'd300, 0, 0, 0);
      begin
        @(negedge clk);
        check("bp_in_ready1", in_ready, 0);
        check("bp_out_inst1", out_inst, exp_q[0].inst);
        @(negedge clk);
        check("bp_in_ready2", in_ready, 0);
        check("bp_out_inst2", out_inst, exp_q[0].inst);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain("bp");
    check("bp_delivered", n_out - base_out, 3);

    // Random legal stream with random back-pressure (enc_cnt saturates)
    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      fmt_r = $urandom_range(0, 5);
      case (fmt_r)
        1, 2:    imm_r = $urandom_range(0, 4095) - 2048;
        3:       imm_r = ($urandom_range(0, 4095) - 2048) * 2;
        4:       imm_r = $urandom & 32'hFFFF_F000;
        5:       imm_r = ($urandom_range(0, 1048575) - 524288) * 2;
        default: imm_r = $urandom;
      endcase
      send(fmt_r, $urandom_range(0, 127), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 127),
           imm_r, 0, 0, 0);
    end
    rand_rdy = 1'b0;
    drain("rand");
    check("enc_sat", enc_cnt, CMAX);

    // Reset with two requests in flight
    out_ready = 1'b0;
    send(1, 'h13, 1, 1, 0, 0, 0, 32'd1, 0, 0, 0);
    send(1, 'h13, 2, 2, 0, 0, 0, 32'd2, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_enc", enc_cnt, 0);
    check("mid_rst_err", err_cnt, 0);
    exp_q.delete();
    enc_m = 0;
    err_m = 0;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("post_rst_idle", out_valid, 0);
    end
    send(2, 'h23, 0, 3, 4, 2, 0, 32'd12, 0, 0, 0);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end
endmodule
